cpsr_writeback: RTL

// - Writeback/commit end of the execute datapath: accepts the ALU result and candidate CPSR word produced per op,

---
 rtl/cpsr_writeback_pkg.sv | 41 ++++
 rtl/cpsr_writeback_cond_eval.sv | 40 ++++
 rtl/cpsr_writeback.sv | 107 ++++++++++
 3 files changed

// File: rtl/cpsr_writeback_pkg.sv
// Shared definitions for the writeback/commit block: CPSR flag positions,
// condition-code encodings and the writeback queue entry layout.
package cpsr_writeback_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 4;

  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  // flags holds CPSR[31:28] in the same order (N,Z,C,V from MSB).
  typedef struct packed {
    logic [WB_DATA_W-1:0]     result;
    logic [3:0]               flags;
    logic [WB_REG_ADDR_W-1:0] dst;
    logic                     rf_we;
    logic                     flag_we;
  } wb_entry_t;

endpackage

// File: rtl/cpsr_writeback_cond_eval.sv
// Combinational condition-code evaluator over the N,Z,C,V nibble.
// Shared between the commit stage and branch decode.
module cpsr_writeback_cond_eval
  import cpsr_writeback_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[CPSR_N - CPSR_V];
  assign z = flags[CPSR_Z - CPSR_V];
  assign c = flags[CPSR_C - CPSR_V];
  assign v = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond_code))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpsr_writeback.sv
// Writeback/commit stage: in-order queue of ALU results and candidate flags,
// drained to the register-file write port and the architectural CPSR.
module cpsr_writeback
  import cpsr_writeback_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W:0]       in_result,
  input  logic [31:0]           in_cpsr_val,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic                  in_rf_we,
  input  logic                  in_flag_we,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data,
  input  logic                  rf_wr_ready,
  output logic [31:0]           cpsr_q,
  output logic                  flags_pending,
  input  logic [3:0]            cond_code,
  output logic                  cond_pass
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  wb_entry_t        head;
  wb_entry_t        in_entry;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       flags_q;
  logic             empty, push, commit;
  logic             unused_bits;

  // Carry-out and the non-flag CPSR bits are deliberately dropped.
  assign unused_bits = ^{in_result[DATA_W], in_cpsr_val[CPSR_V-1:0]};

  assign in_entry = '{result:  in_result[DATA_W-1:0],
                      flags:   in_cpsr_val[CPSR_N:CPSR_V],
                      dst:     in_dst,
                      rf_we:   in_rf_we,
                      flag_we: in_flag_we};

  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign commit   = !empty & (!head.rf_we | rf_wr_ready);

  // Reset gates the strobe so a queued entry never writes during the reset cycle.
  assign rf_wr_en   = !rst & !empty & head.rf_we;
  assign rf_wr_addr = empty ? '0 : head.dst;
  assign rf_wr_data = empty ? '0 : head.result;
  assign cpsr_q     = {flags_q, 28'h0};

  always_comb begin
    flags_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && mem[rd_ptr + PTR_W'(i)].flag_we) begin
        flags_pending = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      flags_q <= 4'h0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (commit) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head.flag_we) begin
          flags_q <= head.flags;
        end
      end
      case ({push, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  cpsr_writeback_cond_eval u_cond_eval (
    .cond_code (cond_code),
    .flags     (flags_q),
    .pass      (cond_pass)
  );

endmodule
